mac_accum_n: RTL and testbench

Parametrised, pipelined signed multiply-accumulate unit. It is the next generation of the fixed 4-bit, 9-term MAC. It accepts one (data, weight) pair per cycle under a valid qualifier and accumulates LEN products into one window. It emits the window sum with a one-cycle valid pulse and starts the next window with no bubble. Added over the fixed MAC: input stalls, a synchronous window flush, optional saturation and an overflow flag. It sits in the datapath between the sample/weight feeders and the downstream activation/result logic.

---
 rtl/mac_accum_n.sv | 137 +++++++++++++
 tb/tb_mac_accum_n.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/mac_accum_n.sv
// mac_accum_n -- pipelined signed multiply-accumulate over windows of LEN products.
//
// Stage 1 registers the signed product of each accepted (data, weight) pair
// together with a flag marking the last sample of the window. Stage 2 adds the
// product into the accumulator, optionally saturating, and on the last product
// publishes the window sum and restarts from zero with no bubble.
//
// Ports:
//   clk        rising-edge clock
//   rstb       synchronous active-low reset
//   in_valid   in_data/in_weight valid this cycle
//   in_data    signed sample, DW bits
//   in_weight  signed weight, WW bits
//   clr        synchronous flush of the partial window (below reset priority)
//   out_valid  one-cycle pulse: out_data/out_ovf hold a completed window
//   out_data   signed window sum, ACCW bits (held between completions)
//   out_ovf    window left the ACCW signed range at some accumulate step
module mac_accum_n #(
  parameter int DW   = 4,
  parameter int WW   = 4,
  parameter int ACCW = 12,
  parameter int LEN  = 9,
  parameter int SAT  = 1
) (
  input  logic            clk,
  input  logic            rstb,
  input  logic            in_valid,
  input  logic [DW-1:0]   in_data,
  input  logic [WW-1:0]   in_weight,
  input  logic            clr,
  output logic            out_valid,
  output logic [ACCW-1:0] out_data,
  output logic            out_ovf
);

  localparam int PW = DW + WW;
  localparam int CW = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [CW-1:0]   LAST_CNT = CW'(LEN - 1);
  localparam logic [ACCW-1:0] MAX_V    = {1'b0, {(ACCW-1){1'b1}}};
  localparam logic [ACCW-1:0] MIN_V    = {1'b1, {(ACCW-1){1'b0}}};

  // Stage 1 state
  logic [CW-1:0]   r_scnt;
  logic [PW-1:0]   r_prod;
  logic            r_pvld;
  logic            r_plast;

  // Stage 2 state
  logic [ACCW-1:0] r_acc;
  logic            r_ovf_s;
  logic            r_out_valid;
  logic [ACCW-1:0] r_out_data;
  logic            r_out_ovf;

  // Full-width signed product: both operands sign-extended to PW bits first
  logic signed [PW-1:0] w_data_x;
  logic signed [PW-1:0] w_weight_x;
  logic signed [PW-1:0] w_prod;
  logic                 w_last;

  assign w_data_x   = {{WW{in_data[DW-1]}}, in_data};
  assign w_weight_x = {{DW{in_weight[WW-1]}}, in_weight};
  assign w_prod     = w_data_x * w_weight_x;
  assign w_last     = (r_scnt == LAST_CNT);

  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_scnt  <= '0;
      r_prod  <= '0;
      r_pvld  <= 1'b0;
      r_plast <= 1'b0;
    end else if (clr) begin
      r_scnt  <= '0;
      r_pvld  <= 1'b0;
      r_plast <= 1'b0;
    end else if (in_valid) begin
      r_prod  <= w_prod;
      r_pvld  <= 1'b1;
      r_plast <= w_last;
      r_scnt  <= w_last ? '0 : r_scnt + 1'b1;
    end else begin
      r_pvld  <= 1'b0;
    end
  end

  // One guard bit above ACCW: overflow shows as the top two bits disagreeing
  logic [ACCW:0]   w_acc_x;
  logic [ACCW:0]   w_prod_x;
  logic [ACCW:0]   w_sum;
  logic            w_ovf;
  logic [ACCW-1:0] w_res;

  assign w_acc_x  = {r_acc[ACCW-1], r_acc};
  assign w_prod_x = {{(ACCW+1-PW){r_prod[PW-1]}}, r_prod};
  assign w_sum    = w_acc_x + w_prod_x;
  assign w_ovf    = w_sum[ACCW] ^ w_sum[ACCW-1];

  always_comb begin
    w_res = w_sum[ACCW-1:0];
    if (SAT != 0 && w_ovf) begin
      w_res = w_sum[ACCW] ? MIN_V : MAX_V;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstb) begin
      r_acc       <= '0;
      r_ovf_s     <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ovf   <= 1'b0;
    end else if (clr) begin
      r_acc       <= '0;
      r_ovf_s     <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (r_pvld) begin
        if (r_plast) begin
          r_out_data  <= w_res;
          r_out_ovf   <= r_ovf_s | w_ovf;
          r_out_valid <= 1'b1;
          r_acc       <= '0;
          r_ovf_s     <= 1'b0;
        end else begin
          r_acc       <= w_res;
          r_ovf_s     <= r_ovf_s | w_ovf;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_mac_accum_n.sv
// tb_mac_accum_n -- four configurations of mac_accum_n driven with one shared
// stimulus stream: default, ACCW=8 saturating, ACCW=8 wrapping, LEN=1.
// Window expectations for the LEN=9 instances come from a hand-derived table;
// the LEN=1 instance is predicted by a product model. Results are queued with
// their due edge and compared when the DUT pulses out_valid.
module tb_mac_accum_n;

  localparam int NDUT = 4;

  logic       clk = 1'b0;
  logic       rstb;
  logic       in_valid;
  logic       clr;
  logic [3:0] in_data;
  logic [3:0] in_weight;

  logic [NDUT-1:0] ov;
  logic [NDUT-1:0] oo;
  logic [11:0]     od0;
  logic [7:0]      od1;
  logic [7:0]      od2;
  logic [11:0]     od3;
  int              odv [NDUT];

  always #5 clk = ~clk;

  mac_accum_n u_def (
    .clk(clk), .rstb(rstb), .in_valid(in_valid), .in_data(in_data),
    .in_weight(in_weight), .clr(clr),
    .out_valid(ov[0]), .out_data(od0), .out_ovf(oo[0]));

  mac_accum_n #(.ACCW(8), .SAT(1)) u_s8 (
    .clk(clk), .rstb(rstb), .in_valid(in_valid), .in_data(in_data),
    .in_weight(in_weight), .clr(clr),
    .out_valid(ov[1]), .out_data(od1), .out_ovf(oo[1]));

  mac_accum_n #(.ACCW(8), .SAT(0)) u_w8 (
    .clk(clk), .rstb(rstb), .in_valid(in_valid), .in_data(in_data),
    .in_weight(in_weight), .clr(clr),
    .out_valid(ov[2]), .out_data(od2), .out_ovf(oo[2]));

  mac_accum_n #(.LEN(1)) u_l1 (
    .clk(clk), .rstb(rstb), .in_valid(in_valid), .in_data(in_data),
    .in_weight(in_weight), .clr(clr),
    .out_valid(ov[3]), .out_data(od3), .out_ovf(oo[3]));

  always_comb begin
    odv[0] = int'($signed(od0));
    odv[1] = int'($signed(od1));
    odv[2] = int'($signed(od2));
    odv[3] = int'($signed(od3));
  end

  typedef struct {
    int data;
    bit ovf;
    int due;
  } exp_t;

  exp_t sbq [NDUT][$];

  int n_vec  = 0;
  int n_miss = 0;
  int ecnt   = 0;

  int last_d [NDUT];
  bit last_o [NDUT];

  // LEN=1 model: sample accepted at one edge, result due at the next
  bit pend_v = 1'b0;
  int pend_p = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, ecnt);
    end
  endtask

  always @(posedge clk) begin
    #1;
    ecnt++;
    if (pend_v && rstb && !clr) begin
      sbq[3].push_back('{pend_p, 1'b0, ecnt});
    end
    pend_v = rstb && !clr && in_valid;
    pend_p = int'($signed(in_data)) * int'($signed(in_weight));

    for (int i = 0; i < NDUT; i++) begin
      if (!rstb) begin
        chk($sformatf("dut%0d reset valid", i), int'(ov[i]), 0);
        chk($sformatf("dut%0d reset data", i), odv[i], 0);
        chk($sformatf("dut%0d reset ovf", i), int'(oo[i]), 0);
        last_d[i] = 0;
        last_o[i] = 1'b0;
      end else if (ov[i]) begin
        if (sbq[i].size() == 0) begin
          chk($sformatf("dut%0d spurious pulse", i), 1, 0);
        end else begin
          exp_t e;
          e = sbq[i].pop_front();
          chk($sformatf("dut%0d data", i), odv[i], e.data);
          chk($sformatf("dut%0d ovf", i), int'(oo[i]), int'(e.ovf));
          chk($sformatf("dut%0d pulse edge", i), ecnt, e.due);
          last_d[i] = e.data;
          last_o[i] = e.ovf;
        end
      end else begin
        chk($sformatf("dut%0d hold data", i), odv[i], last_d[i]);
        chk($sformatf("dut%0d hold ovf", i), int'(oo[i]), int'(last_o[i]));
      end
    end
  end

  task automatic drive(input bit v, input int d, input int w, input bit c);
    @(negedge clk);
    in_valid  = v;
    in_data   = 4'(d);
    in_weight = 4'(w);
    clr       = c;
  endtask

  // Called right after the last sample of a window has been driven
  task automatic push_win(input int e0, input bit o0, input int e1, input bit o1,
                          input int e2, input bit o2);
    sbq[0].push_back('{e0, o0, ecnt + 2});
    sbq[1].push_back('{e1, o1, ecnt + 2});
    sbq[2].push_back('{e2, o2, ecnt + 2});
  endtask

  typedef struct {
    int d;
    int w;
    int stall_after;  // stall inserted after this many samples (0 = none)
    int stall_len;
    int e_def; bit o_def;
    int e_s8;  bit o_s8;
    int e_w8;  bit o_w8;
  } win_t;

  win_t tbl [6];

  initial begin
    rstb      = 1'b0;
    in_valid  = 1'b0;
    clr       = 1'b0;
    in_data   = '0;
    in_weight = '0;

    //          d   w  stall   def        sat8       wrap8
    tbl[0] = '{ 3,  2, 0, 0,   54, 1'b0,   54, 1'b0,  54, 1'b0};
    tbl[1] = '{-8, -8, 0, 0,  576, 1'b0,  127, 1'b1,  64, 1'b1};
    tbl[2] = '{ 3,  2, 4, 3,   54, 1'b0,   54, 1'b0,  54, 1'b0};
    tbl[3] = '{ 7,  7, 0, 0,  441, 1'b0,  127, 1'b1, -71, 1'b1};
    tbl[4] = '{ 1,  1, 0, 0,    9, 1'b0,    9, 1'b0,   9, 1'b0};
    tbl[5] = '{-8,  7, 0, 0, -504, 1'b0, -128, 1'b1,   8, 1'b1};

    repeat (3) @(negedge clk);
    rstb = 1'b1;

    // Back-to-back windows, one with a mid-window stall
    for (int k = 0; k < 6; k++) begin
      for (int s = 0; s < 9; s++) begin
        drive(1'b1, tbl[k].d, tbl[k].w, 1'b0);
        if (s == 8)
          push_win(tbl[k].e_def, tbl[k].o_def, tbl[k].e_s8, tbl[k].o_s8,
                   tbl[k].e_w8, tbl[k].o_w8);
        if (s + 1 == tbl[k].stall_after)
          repeat (tbl[k].stall_len) drive(1'b0, 0, 0, 1'b0);
      end
    end
    repeat (3) drive(1'b0, 0, 0, 1'b0);

    // Stream 1, -2, 3 with w=-3 (three LEN=1 pulses), padded to a full window
    drive(1'b1,  1, -3, 1'b0);
    drive(1'b1, -2, -3, 1'b0);
    drive(1'b1,  3, -3, 1'b0);
    for (int s = 0; s < 6; s++) begin
      drive(1'b1, 0, 0, 1'b0);
      if (s == 5) push_win(-6, 1'b0, -6, 1'b0, -6, 1'b0);
    end
    repeat (2) drive(1'b0, 0, 0, 1'b0);

    // Flush after 5 samples; the sample offered with clr is discarded
    repeat (5) drive(1'b1, 2, 2, 1'b0);
    drive(1'b1, 2, 2, 1'b1);
    for (int s = 0; s < 9; s++) begin
      drive(1'b1, 1, -1, 1'b0);
      if (s == 8) push_win(-9, 1'b0, -9, 1'b0, -9, 1'b0);
    end
    repeat (2) drive(1'b0, 0, 0, 1'b0);

    // Reset mid-window after 6 samples
    repeat (6) drive(1'b1, 1, 1, 1'b0);
    @(negedge clk);
    rstb     = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rstb = 1'b1;
    for (int s = 0; s < 9; s++) begin
      drive(1'b1, 1, 1, 1'b0);
      if (s == 8) push_win(9, 1'b0, 9, 1'b0, 9, 1'b0);
    end

    // Bounded drain: every queued result must have appeared by now
    repeat (5) drive(1'b0, 0, 0, 1'b0);
    for (int i = 0; i < NDUT; i++)
      chk($sformatf("dut%0d missing pulses", i), sbq[i].size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
